// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: state encoding and default constants for the run sequencer
package run_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  localparam int RUN_SEQ_RST_CYCLES   = 2;
  localparam int RUN_SEQ_DRAIN_CYCLES = 10;
  localparam int RUN_SEQ_MAX_CYCLES   = 100000;
  localparam int RUN_SEQ_CNT_W        = 32;
  localparam int RUN_SEQ_PC_W         = 32;
  localparam int RUN_SEQ_STALL_CYCLES = 8;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/run_seq_counter.sv
// run_seq_counter: loadable down-counter that stops at zero and flags it
module run_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= load ? value : (en && count != '0) ? count - 1'b1 : count;
  assign zero = count == '0;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: reset/run/drain/dump controller for the core; define RUN_SEQ_STALL_DETECT_EN to also end runs on a stalled pc
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int RST_CYCLES   = RUN_SEQ_RST_CYCLES,
  parameter int DRAIN_CYCLES = RUN_SEQ_DRAIN_CYCLES,
  parameter int MAX_CYCLES   = RUN_SEQ_MAX_CYCLES,
  parameter int CNT_W        = RUN_SEQ_CNT_W,
  parameter int PC_W         = RUN_SEQ_PC_W,
  parameter int STALL_CYCLES = RUN_SEQ_STALL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_end,
  input  logic             ext_hold,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             hold,
  output logic             dump_all,
  output logic             done,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int SW = $clog2(max2(RST_CYCLES, DRAIN_CYCLES) + 1);
  state_t st, st_n;
  logic go, run, wd, stall, run_exit, seq_zero;
  assign run = st == S_RUN;
  assign go = start && (st == S_IDLE || st == S_DONE);
  assign wd = run && !ext_hold && cycle_count == CNT_W'(MAX_CYCLES - 1);
  assign run_exit = run && (mem_end || wd || stall);
  assign state = st;
  run_seq_counter #(.W(SW)) u_seq (
    .clk(clk),
    .reset(reset),
    .load(go || run_exit),
    .en(st == S_RST || st == S_DRAIN),
    .value(go ? SW'(RST_CYCLES - 1) : SW'(DRAIN_CYCLES - 1)),
    .zero(seq_zero)
  );
`ifdef RUN_SEQ_STALL_DETECT_EN
  localparam int TW = $clog2(STALL_CYCLES + 1);
  logic [PC_W-1:0] pc_q;
  logic same, stall_zero;
  assign same = pc == pc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else pc_q <= pc;
  run_seq_counter #(.W(TW)) u_stall (
    .clk(clk),
    .reset(reset),
    .load((st == S_RST && seq_zero) || (run && !same)),
    .en(run && same && !ext_hold),
    .value(TW'(STALL_CYCLES - 1)),
    .zero(stall_zero)
  );
  assign stall = run && same && !ext_hold && stall_zero;
`else
  logic unused_pc;
  assign unused_pc = ^pc ^ STALL_CYCLES[0];
  assign stall = 1'b0;
`endif
  always_comb begin
    st_n = go ? S_RST
         : (st == S_RST && seq_zero) ? S_RUN
         : run_exit ? S_DRAIN
         : (st == S_DRAIN && seq_zero) ? S_DUMP
         : st == S_DUMP ? S_DONE
         : st;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st          <= S_IDLE;
      core_reset  <= 1'b1;
      hold        <= 1'b1;
      dump_all    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      st          <= st_n;
      core_reset  <= st_n == S_IDLE || st_n == S_RST;
      hold        <= st_n == S_RUN ? ext_hold : st_n != S_RST;
      dump_all    <= st_n == S_DUMP;
      done        <= st_n == S_DONE;
      timeout     <= go ? 1'b0 : (wd && !mem_end && !stall) ? 1'b1 : timeout;
      cycle_count <= go ? '0 : (run && !ext_hold && !(&cycle_count)) ? cycle_count + 1'b1 : cycle_count;
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table-driven runs with a scoreboard of expected end-of-run results
module tb_run_sequencer;
  localparam int RST_CYCLES = 2;
  localparam int DRAIN_CYCLES = 10;
  localparam int MAX_CYCLES = 60;
  localparam int CNT_W = 16;
  typedef struct {
    int end_at;
    int h_start;
    int h_len;
    int start_at;
    int pc_mode;
    int exp_exit;
    int exp_count;
    bit exp_to;
  } run_vec_t;
  typedef struct {
    int count;
    bit to;
  } exp_t;
  logic clk = 0, reset = 0, start = 0, mem_end = 0, ext_hold = 0;
  logic [31:0] pc = '0;
  logic core_reset, hold, dump_all, done, timeout;
  logic [2:0] state;
  logic [CNT_W-1:0] cycle_count;
  int n_tests = 0, n_fail = 0;
  run_vec_t vecs[$];
  exp_t sbq[$];
  run_sequencer #(
    .RST_CYCLES(RST_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .CNT_W(CNT_W), .PC_W(32), .STALL_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mem_end(mem_end), .ext_hold(ext_hold),
    .pc(pc), .core_reset(core_reset), .hold(hold), .dump_all(dump_all), .done(done),
    .timeout(timeout), .state(state), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic do_run(input run_vec_t v);
    int k, d;
    exp_t e;
    pc = v.pc_mode == 1 ? 32'h40 : 32'h100;
    sbq.push_back('{v.exp_count, v.exp_to});
    start = 1;
    tick();
    start = 0;
    chk("start_state", state, 1);
    chk("start_done_clr", done, 0);
    chk("start_to_clr", timeout, 0);
    chk("start_cnt_clr", cycle_count, 0);
    d = 0;
    while (core_reset && d < 20) begin
      tick();
      d++;
    end
    chk("rst_cycles", d, RST_CYCLES);
    chk("run_entry", state, 2);
    k = 0;
    while (state == 3'd2 && k < 200) begin
      k++;
      mem_end = k == v.end_at;
      ext_hold = k >= v.h_start && k < v.h_start + v.h_len;
      start = k == v.start_at;
      pc = v.pc_mode == 0 ? 32'(k * 4) : v.pc_mode == 1 ? 32'h40 : 32'h100 + 32'(4 * (k / 7));
      tick();
      if (state == 3'd2) chk("hold_mirror", hold, ext_hold);
    end
    start = 0;
    ext_hold = 1;
    mem_end = 1;
    chk("exit_cycle", k, v.exp_exit);
    chk("exit_state", state, 3);
    chk("exit_hold", hold, 1);
    chk("exit_core_reset", core_reset, 0);
    d = 0;
    while (!dump_all && d < 50) begin
      tick();
      d++;
    end
    ext_hold = 0;
    mem_end = 0;
    chk("drain_len", d, DRAIN_CYCLES);
    tick();
    chk("dump_single", dump_all, 0);
    chk("done_state", state, 5);
    chk("done_flag", done, 1);
    chk("done_hold", hold, 1);
    if (sbq.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sbq.pop_front();
      chk("cycle_count", cycle_count, e.count);
      chk("timeout", timeout, e.to);
    end
    tick();
    chk("done_sticky", done, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    bit saw_dump;
    int d;
    vecs.push_back('{50, 0, 0, 20, 0, 50, 50, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 60, 60, 1});
    vecs.push_back('{40, 10, 5, 0, 0, 40, 35, 0});
    vecs.push_back('{65, 10, 5, 0, 0, 65, 60, 0});
    vecs.push_back('{0, 20, 5, 30, 0, 65, 60, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{12, 10, 5, 0, 0, 12, 9, 0});
`ifdef RUN_SEQ_STALL_DETECT_EN
    vecs.push_back('{0, 0, 0, 0, 1, 8, 8, 0});
    vecs.push_back('{30, 0, 0, 0, 2, 30, 30, 0});
`endif
    #1 reset = 1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_hold", hold, 1);
    chk("rst_dump", dump_all, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", cycle_count, 0);
    tick();
    reset = 0;
    repeat (3) tick();
    chk("idle_stays", state, 0);
    chk("idle_core_reset", core_reset, 1);
    for (int i = 0; i < vecs.size(); i++) do_run(vecs[i]);
    start = 1;
    tick();
    start = 0;
    d = 0;
    while (state != 3'd2 && d < 20) begin
      tick();
      d++;
    end
    mem_end = 1;
    tick();
    mem_end = 0;
    chk("mid_drain_state", state, 3);
    repeat (2) tick();
    #3 reset = 1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_core_reset", core_reset, 1);
    chk("async_rst_dump", dump_all, 0);
    tick();
    reset = 0;
    saw_dump = 0;
    repeat (15) begin
      tick();
      saw_dump |= dump_all;
    end
    chk("no_dump_after_rst", saw_dump, 0);
    chk("idle_after_rst", state, 0);
    do_run('{30, 0, 0, 0, 0, 30, 30, 0});
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Synthesizable run controller that sequences one program execution of mod_mips_processor: it holds the core in reset, runs it, detects end of program, drains, then dumps. It replaces the fixed-delay end-of-run logic in bench code with a parametrised, cycle-exact FSM. It adds a watchdog timeout, an external pause and a retired-cycle counter. It sits between the instruction ROM (mem_end), the core (reset/hold/dump_all/rg_pc) and the bench or host.

Parameters:
RST_CYCLES, 2, cycles core_reset stays high after start (min 1)
DRAIN_CYCLES, 10, cycles hold=1 before dump (min 1)
MAX_CYCLES, 100000, RUN-state watchdog limit
CNT_W, 32, cycle_count width; must satisfy 2^CNT_W > MAX_CYCLES
PC_W, 32, width of pc input
STALL_CYCLES, 8, identical-PC cycles treated as end (optional feature only)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; launches a run from IDLE or DONE
mem_end  in  1  end-of-program flag from instruction ROM
ext_hold  in  1  debug pause request, honoured in RUN only
pc  in  PC_W  core rg_pc
core_reset  out  1  reset to core
hold  out  1  hold to core
dump_all  out  1  dump strobe to core and data memory
done  out  1  run finished (sticky until next start or reset)
timeout  out  1  run ended by watchdog (sticky like done)
state  out  3  current FSM state encoding
cycle_count  out  CNT_W  RUN cycles in which the core advanced

Behaviour:
- Reset (async): state=IDLE, core_reset=1, hold=1, dump_all=0, done=0, timeout=0, cycle_count=0, internal counters 0.
- All outputs are registered and change only on the rising clk edge, except on async reset.
- IDLE: core_reset=1, hold=1. start -> RST; clear done, timeout, cycle_count.
- RST: core_reset=1, hold=0 for exactly RST_CYCLES cycles -> RUN.
- RUN: core_reset=0, hold=ext_hold.
  - cycle_count increments by 1 in each RUN cycle where ext_hold=0. It saturates at the all-ones value and never wraps.
  - mem_end=1 -> DRAIN. This is sampled every RUN cycle, including ext_hold cycles.
  - Watchdog: when the RUN cycle counter (ext_hold cycles excluded) reaches MAX_CYCLES, go to DRAIN with timeout=1.
  - mem_end and watchdog in the same cycle: go to DRAIN with timeout=0, because mem_end has priority.
- DRAIN: hold=1, core_reset=0 for DRAIN_CYCLES cycles -> DUMP. mem_end and ext_hold are ignored.
- DUMP: dump_all=1 for exactly one cycle, hold=1 -> DONE.
- DONE: hold=1, done=1, dump_all=0. start -> RST and clears done, timeout and cycle_count.
- start is ignored in RST, RUN, DRAIN and DUMP.
- State encoding: IDLE=0, RST=1, RUN=2, DRAIN=3, DUMP=4, DONE=5.
- Latency: mem_end high at edge N gives hold=1 from edge N+1, and dump_all high for the single cycle at edge N+1+DRAIN_CYCLES.
- Reset mid-run: the block returns to IDLE immediately, drives core_reset=1, and drops any pending dump.

Optional Feature:
RUN_SEQ_STALL_DETECT_EN
- Defined: in RUN, a counter tracks consecutive cycles with ext_hold=0 in which pc equals its previous-cycle value. The counter resets on any pc change.
- When the counter reaches STALL_CYCLES, go to DRAIN, identical to a mem_end exit (timeout=0). This covers a `j .` self-loop halt.
- The counter is cleared on entry to RUN.
- Undefined: pc is unused and only mem_end or the watchdog end a run; no extra flops.

Decomposition:
- Shared package / defines header (`include style, alongside instruction_defines.v) holds the state encodings and RUN_SEQ_* default constants.
- One natural sub-module: run_seq_counter, a loadable down-counter with a zero flag. It is reused for the RST, DRAIN and optional stall counts.
- cycle_count and the watchdog stay inline.

Test Plan:
1. Normal end: reset, start, mem_end at RUN cycle 50 -> cycle_count=50, hold from next edge, dump_all single pulse 10 cycles later, done=1, timeout=0.
2. Watchdog: MAX_CYCLES=20, mem_end held 0 -> DRAIN after 20 RUN cycles, timeout=1, done=1, cycle_count=20.
3. Pause and tie: ext_hold high for 5 cycles mid-run -> hold mirrors it and cycle_count excludes those 5. mem_end and watchdog in the same cycle -> timeout=0.
4. Reset mid-DRAIN: async reset at DRAIN cycle 3 -> state=0, core_reset=1, dump_all never pulses. Then start, mem_end at cycle 30 -> normal completion, cycle_count=30.
5. Restart and ignore: start during RUN has no effect. start in DONE -> done and timeout clear, core_reset=1 for exactly RST_CYCLES.
6. With RUN_SEQ_STALL_DETECT_EN: pc fixed at 0x40 for 8 cycles -> DRAIN, timeout=0. pc changing every 7 cycles -> no stall exit.
